// File: rtl/ref_addr_gen.sv
// Reference-window address generator: one row address per window row, with the
// window origin clamped to the frame and downstream back-pressure on each row.
module ref_addr_gen #(
  parameter int FRAME_W = 176,
  parameter int FRAME_H = 144,
  parameter int MB      = 16,
  parameter int WIN     = 23,
  parameter int OFF     = 4,
  parameter int AW      = 25
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [3:0]    mb_x,
  input  logic [3:0]    mb_y,
  input  logic          plane,
  input  logic [AW-1:0] frame_base,
  input  logic          ready,
  output logic [AW-1:0] ad1,
  output logic          ber,
  output logic          valid,
  output logic [4:0]    row_idx,
  output logic          last,
  output logic [7:0]    win_x,
  output logic [7:0]    win_y,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [4:0] LAST_ROW = 5'(WIN - 1);

  state_t        state_q, state_d;
  logic [3:0]    mb_x_q, mb_x_d;
  logic [3:0]    mb_y_q, mb_y_d;
  logic          plane_q, plane_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] ad1_q, ad1_d;
  logic          ber_q, ber_d;
  logic          valid_q, valid_d;
  logic [4:0]    row_idx_q, row_idx_d;
  logic          last_q, last_d;
  logic [7:0]    win_x_q, win_x_d;
  logic [7:0]    win_y_q, win_y_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  int ux_i, uy_i, wx_i, wy_i, row_off_i;

  always_comb begin
    state_d   = state_q;
    mb_x_d    = mb_x_q;
    mb_y_d    = mb_y_q;
    plane_d   = plane_q;
    base_d    = base_q;
    ad1_d     = ad1_q;
    ber_d     = ber_q;
    row_idx_d = row_idx_q;
    win_x_d   = win_x_q;
    win_y_d   = win_y_q;
    ux_i      = 0;
    uy_i      = 0;
    wx_i      = 0;
    wy_i      = 0;
    row_off_i = 0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mb_x_d  = mb_x;
          mb_y_d  = mb_y;
          plane_d = plane;
          base_d  = frame_base;
          state_d = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        // Unclamped origin may go negative at the top/left edge.
        ux_i = int'(mb_x_q) * MB - OFF;
        uy_i = int'(mb_y_q) * MB - OFF;
        if (ux_i < 0) begin
          wx_i = 0;
        end else if (ux_i > FRAME_W - WIN) begin
          wx_i = FRAME_W - WIN;
        end else begin
          wx_i = ux_i;
        end
        if (uy_i < 0) begin
          wy_i = 0;
        end else if (uy_i > FRAME_H - WIN) begin
          wy_i = FRAME_H - WIN;
        end else begin
          wy_i = uy_i;
        end
        row_off_i = wy_i * FRAME_W + wx_i;
        win_x_d   = 8'(wx_i);
        win_y_d   = 8'(wy_i);
        ad1_d     = base_q + AW'(row_off_i);
        ber_d     = plane_q;
        row_idx_d = 5'd0;
        state_d   = S_RUN;
      end
      S_RUN: begin
        if (valid_q && ready) begin
          if (row_idx_q == LAST_ROW) begin
            state_d = S_DONE;
          end else begin
            ad1_d     = ad1_q + AW'(FRAME_W);
            row_idx_d = row_idx_q + 5'd1;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status outputs are registered copies of what the next state implies.
    busy_d  = (state_d != S_IDLE);
    valid_d = (state_d == S_RUN);
    done_d  = (state_d == S_DONE);
    last_d  = valid_d && (row_idx_d == LAST_ROW);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mb_x_q    <= 4'd0;
      mb_y_q    <= 4'd0;
      plane_q   <= 1'b0;
      base_q    <= '0;
      ad1_q     <= '0;
      ber_q     <= 1'b0;
      valid_q   <= 1'b0;
      row_idx_q <= 5'd0;
      last_q    <= 1'b0;
      win_x_q   <= 8'd0;
      win_y_q   <= 8'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mb_x_q    <= mb_x_d;
      mb_y_q    <= mb_y_d;
      plane_q   <= plane_d;
      base_q    <= base_d;
      ad1_q     <= ad1_d;
      ber_q     <= ber_d;
      valid_q   <= valid_d;
      row_idx_q <= row_idx_d;
      last_q    <= last_d;
      win_x_q   <= win_x_d;
      win_y_q   <= win_y_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign ad1     = ad1_q;
  assign ber     = ber_q;
  assign valid   = valid_q;
  assign row_idx = row_idx_q;
  assign last    = last_q;
  assign win_x   = win_x_q;
  assign win_y   = win_y_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: doc/ref_addr_gen.md
# ref_addr_gen

Generates the reference-window read addresses for the motion-estimation datapath. For each 16x16 current macroblock it produces one address per window row and a plane-select bit (`ber`). Together these drive the 23-pixel-wide reference memory port, which returns 23 consecutive 4-bit pixels starting at `ad1`. The block clamps the search window to the frame, supports downstream back-pressure, and reports the window origin so the SAD array can map its motion vectors.

## Interface

Parameters:
- `FRAME_W`, 176: frame width in pixels (QCIF); also the row pitch in address units.
- `FRAME_H`, 144: frame height in pixels.
- `MB`, 16: macroblock size.
- `WIN`, 23: window width and height (rows emitted per macroblock).
- `OFF`, 4: offset of the unclamped window origin above and left of the macroblock origin.
- `AW`, 25: address width.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request; accepted only in IDLE.
- `mb_x`  in  4  macroblock column index; the legal range is 0..10.
- `mb_y`  in  4  macroblock row index; the legal range is 0..8.
- `plane`  in  1  nibble plane; copied to `ber` for the whole window.
- `frame_base`  in  AW  address of pixel (0,0) of the reference frame.
- `ready`  in  1  downstream accepts the current address.
- `ad1`  out  AW  address of the leftmost pixel of the current window row.
- `ber`  out  1  plane select; 1 selects nibble [3:0], 0 selects [7:4].
- `valid`  out  1  `ad1`/`ber`/`row_idx` are meaningful.
- `row_idx`  out  5  current window row, 0..WIN-1.
- `last`  out  1  asserted with `valid` on row WIN-1.
- `win_x`  out  8  clamped window origin x.
- `win_y`  out  8  clamped window origin y.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last row is accepted.

## Operation

- The state machine has four states: IDLE, SETUP, RUN and DONE.
- IDLE:
  - When `start` is high, latch `mb_x`, `mb_y`, `plane` and `frame_base`, then go to SETUP.
  - `start` in any other state is ignored; there is no queueing.
- SETUP (exactly one cycle):
  - Compute the unclamped origin `ux = mb_x*MB - OFF`, evaluated signed.
  - `win_x` = 0 if `ux < 0`; `FRAME_W-WIN` if `ux > FRAME_W-WIN`; otherwise `ux`.
  - `win_y` follows the same rule, using `mb_y` and `FRAME_H`.
  - Load `ad1 = frame_base + win_y*FRAME_W + win_x` (constant multiply, truncated to AW bits).
  - Load `row_idx = 0`, then go to RUN.
- RUN:
  - `valid` = 1.
  - On `valid && ready` with `row_idx < WIN-1`: `ad1 += FRAME_W` and `row_idx += 1`.
  - On `valid && ready` with `row_idx == WIN-1`: go to DONE.
  - When `ready` = 0, all outputs hold.
- DONE: assert `done` for one cycle, drop `valid`, return to IDLE.
- `last` = `valid && row_idx == WIN-1`.
- `ber`, `win_x` and `win_y` stay constant from SETUP until the next accepted `start`.
- Out-of-range `mb_x`/`mb_y` are not errors; the clamp applies (for example, `mb_x` = 15 gives `win_x` = 153).
- All address arithmetic wraps modulo 2^AW; no overflow flag.

## Timing

- Reset values: state IDLE; `ad1`, `ber`, `valid`, `row_idx`, `last`, `win_x`, `win_y`, `busy` and `done` all 0.
- Latency: `start` sampled at edge n gives SETUP in cycle n+1 and the first `valid` in cycle n+2.
- With `ready` held high, row k is presented in cycle n+2+k, and `done` pulses in cycle n+2+WIN (n+25).
- Total `busy` duration is WIN+2 cycles plus any stall cycles.
- `ready` is sampled only while `valid` = 1; `ready` during IDLE, SETUP or DONE has no effect.
- A `start` in the same cycle as `done` is ignored; a new `start` is accepted from the following IDLE cycle.
- `rst` mid-operation: the next edge forces IDLE and all outputs to their reset values. No `done` is emitted for the aborted window.
- `rst` and `start` asserted together: reset wins.

## Test plan

- **Reset then origin macroblock.**
  - Stimulus: `frame_base` = 0, `mb_x` = 0, `mb_y` = 0, `plane` = 0, `ready` = 1.
  - Response: `win_x` = 0, `win_y` = 0, `ber` = 0.
  - `ad1` = 0, 176, …, 3872 on rows 0..22; `last` only with 3872; `done` at n+25.
- **Interior macroblock.**
  - Stimulus: `mb_x` = 5, `mb_y` = 3.
  - Response: `win_x` = 76, `win_y` = 44; first `ad1` = 7820, last `ad1` = 11692.
- **Bottom-right clamp with plane and base.**
  - Stimulus: `mb_x` = 10, `mb_y` = 8, `frame_base` = 25344, `plane` = 1.
  - Response: `win_x` = 153, `win_y` = 121, first `ad1` = 46793, `ber` = 1 throughout.
- **Back-pressure.**
  - Stimulus: `mb_x` = 5, `mb_y` = 3; `ready` = 0 for 3 cycles while `row_idx` = 5.
  - Response: `ad1` holds at 8700 with `valid` = 1 for those cycles; `done` arrives 3 cycles late (n+28).
- **Ignored start.**
  - Stimulus: a second `start` with different `mb_x` at row 10.
  - Response: the sequence is unchanged; `win_x` is unchanged; exactly one `done`.
- **Reset mid-run.**
  - Stimulus: `rst` at row 7.
  - Response: next cycle `valid` = 0, `busy` = 0, `ad1` = 0, no `done`; a fresh `start` then runs a normal window.
